// File: rtl/adia_dualrail_rx_pkg.sv
// Shared adiabatic-interface types: power-clock phase encoding and dual-rail sample classes.
package adia_dualrail_rx_pkg;

  typedef enum logic [1:0] {
    EVAL    = 2'd0,
    HOLD    = 2'd1,
    RECOVER = 2'd2,
    WAIT    = 2'd3
  } phase_e;

  typedef enum logic [1:0] {
    DATA  = 2'd0,
    NULL  = 2'd1,
    ERROR = 2'd2
  } sample_e;

  localparam int         ERR_CNT_W   = 8;
  localparam logic [7:0] ERR_CNT_MAX = 8'hFF;

endpackage

// File: rtl/adia_sync_fifo.sv
// Synchronous FIFO with registered occupancy; the head is shown combinationally and reads zero when empty.
module adia_sync_fifo
  import adia_dualrail_rx_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop_ready,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             drop
);

  localparam int           AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]  CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             full;
  logic             pop;
  logic             push_ok;

  assign full       = (count == CNT_FULL);
  assign dout_valid = (count != '0);
  assign pop        = pop_ready && dout_valid;
  // A pop frees the slot in the same cycle, so a full FIFO still accepts a concurrent push.
  assign push_ok    = push && (!full || pop);
  assign drop       = push && full && !pop;
  assign dout       = dout_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/adia_dualrail_rx.sv
// Dual-rail adiabatic receiver: tracks the four-phase power clock, samples rails in HOLD,
// decodes DATA words into a FIFO and keeps sticky rail-error / overflow status.
module adia_dualrail_rx
  import adia_dualrail_rx_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             phase_sync,
  input  logic [WIDTH-1:0] ad_t,
  input  logic [WIDTH-1:0] ad_f,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             rail_err,
  output logic             overflow,
  input  logic             err_clr,
  output logic [7:0]       err_cnt,
  output logic [1:0]       phase
);

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (v == ERR_CNT_MAX) ? v : v + ERR_CNT_W'(1);
  endfunction

  phase_e  phase_q;
  phase_e  phase_d;
  sample_e cls;
  logic    sample;
  logic    push;
  logic    err_evt;
  logic    drop;

  // The sync cycle itself counts as EVAL, so the following cycle is HOLD.
  always_comb begin
    phase_d = phase_e'(phase_q + 2'd1);
    if (phase_sync) phase_d = HOLD;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) phase_q <= EVAL;
    else        phase_q <= phase_d;
  end

  assign phase = phase_q;

  always_comb begin
    cls = ERROR;
    if ((ad_t ^ ad_f) == '1)             cls = DATA;
    else if ((ad_t == '0) && (ad_f == '0)) cls = NULL;
  end

  assign sample  = (phase_q == HOLD);
  assign push    = sample && (cls == DATA);
  assign err_evt = sample && (cls == ERROR);

  adia_sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .din        (ad_t),
    .pop_ready  (dout_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .drop       (drop)
  );

  // Clear wins over any same-cycle error or drop event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rail_err <= 1'b0;
      overflow <= 1'b0;
      err_cnt  <= '0;
    end else if (err_clr) begin
      rail_err <= 1'b0;
      overflow <= 1'b0;
      err_cnt  <= '0;
    end else begin
      if (err_evt) begin
        rail_err <= 1'b1;
        err_cnt  <= sat_inc(err_cnt);
      end
      if (drop) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_adia_dualrail_rx.sv
// Directed bench for adia_dualrail_rx: phase tracking, decode, error saturation, FIFO order/overflow, reset.
module tb_adia_dualrail_rx;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             phase_sync;
  logic [WIDTH-1:0] ad_t;
  logic [WIDTH-1:0] ad_f;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             dout_ready;
  logic             rail_err;
  logic             overflow;
  logic             err_clr;
  logic [7:0]       err_cnt;
  logic [1:0]       phase;

  int checks   = 0;
  int failures = 0;

  adia_dualrail_rx #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .phase_sync (phase_sync),
    .ad_t       (ad_t),
    .ad_f       (ad_f),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .rail_err   (rail_err),
    .overflow   (overflow),
    .err_clr    (err_clr),
    .err_cnt    (err_cnt),
    .phase      (phase)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse sync, present word w during the following HOLD cycle, return 1ns after the push edge.
  task automatic send_word(input logic [WIDTH-1:0] w);
    phase_sync = 1'b1;
    tick();
    phase_sync = 1'b0;
    ad_t = w;
    ad_f = ~w;
    tick();
    ad_t = '0;
    ad_f = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; phase_sync = 1'b0; ad_t = '0; ad_f = '0;
    dout_ready = 1'b0; err_clr = 1'b0;
    #2;
    checks++;
    if (phase !== 2'd0 || dout_valid !== 1'b0 || dout !== 8'h00) begin
      failures++;
      $display("FAIL reset_out: phase=%0d valid=%b dout=%h, expected 0/0/00", phase, dout_valid, dout);
    end
    checks++;
    if (rail_err !== 1'b0 || overflow !== 1'b0 || err_cnt !== 8'd0) begin
      failures++;
      $display("FAIL reset_flags: rail_err=%b overflow=%b err_cnt=%0d, expected 0/0/0", rail_err, overflow, err_cnt);
    end
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic test_phase();
    logic [1:0] exp_ph [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    checks++;
    if (phase !== 2'd0) begin
      failures++;
      $display("FAIL phase_start: got %0d expected 0", phase);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (phase !== exp_ph[i]) begin
        failures++;
        $display("FAIL phase_step%0d: got %0d expected %0d", i, phase, exp_ph[i]);
      end
    end
    // now in HOLD; a sync here still forces HOLD next, overriding RECOVER
    phase_sync = 1'b1;
    tick();
    phase_sync = 1'b0;
    checks++;
    if (phase !== 2'd1) begin
      failures++;
      $display("FAIL phase_sync: got %0d expected 1", phase);
    end
    tick();
  endtask

  task automatic test_single();
    dout_ready = 1'b1;
    phase_sync = 1'b1;
    tick();
    phase_sync = 1'b0;
    ad_t = 8'hA5;
    ad_f = 8'h5A;
    checks++;
    if (dout_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_pre: valid=%b expected 0", dout_valid);
    end
    tick();
    ad_t = '0; ad_f = '0;
    checks++;
    if (dout_valid !== 1'b1 || dout !== 8'hA5) begin
      failures++;
      $display("FAIL single_out: valid=%b dout=%h expected 1/a5", dout_valid, dout);
    end
    tick();
    checks++;
    if (dout_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_pop: valid=%b expected 0", dout_valid);
    end
  endtask

  task automatic test_null();
    dout_ready = 1'b1;
    ad_t = '0; ad_f = '0;
    phase_sync = 1'b1;
    tick();
    phase_sync = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    checks++;
    if (dout_valid !== 1'b0 || rail_err !== 1'b0 || err_cnt !== 8'd0) begin
      failures++;
      $display("FAIL null: valid=%b rail_err=%b err_cnt=%0d expected 0/0/0", dout_valid, rail_err, err_cnt);
    end
  endtask

  task automatic test_err_sat();
    dout_ready = 1'b1;
    phase_sync = 1'b1;
    tick();
    phase_sync = 1'b0;
    ad_t = 8'hFF; ad_f = 8'h01;
    tick();
    checks++;
    if (rail_err !== 1'b1 || err_cnt !== 8'd1 || dout_valid !== 1'b0) begin
      failures++;
      $display("FAIL err_first: rail_err=%b err_cnt=%0d valid=%b expected 1/1/0", rail_err, err_cnt, dout_valid);
    end
    // mixed null/valid bits are also an error
    ad_t = 8'h0F; ad_f = 8'h00;
    phase_sync = 1'b1;
    tick();
    phase_sync = 1'b0;
    tick();
    checks++;
    if (err_cnt !== 8'd2) begin
      failures++;
      $display("FAIL err_mixed: err_cnt=%0d expected 2", err_cnt);
    end
    ad_t = 8'hFF; ad_f = 8'h01;
    for (int i = 0; i < 1200; i++) tick();
    checks++;
    if (rail_err !== 1'b1 || err_cnt !== 8'd255) begin
      failures++;
      $display("FAIL err_sat: rail_err=%b err_cnt=%0d expected 1/255", rail_err, err_cnt);
    end
    phase_sync = 1'b1;
    tick();
    phase_sync = 1'b0;
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    ad_t = '0; ad_f = '0;
    checks++;
    if (rail_err !== 1'b0 || err_cnt !== 8'd0 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL err_clr: rail_err=%b err_cnt=%0d overflow=%b expected 0/0/0", rail_err, err_cnt, overflow);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] exp_w [4] = '{8'd1, 8'd2, 8'd3, 8'd4};
    dout_ready = 1'b0;
    for (int w = 1; w <= 4; w++) send_word(8'(w));
    checks++;
    if (overflow !== 1'b0 || dout !== 8'd1 || dout_valid !== 1'b1) begin
      failures++;
      $display("FAIL ovf_full: overflow=%b dout=%0d valid=%b expected 0/1/1", overflow, dout, dout_valid);
    end
    send_word(8'd5);
    checks++;
    if (overflow !== 1'b1 || dout !== 8'd1) begin
      failures++;
      $display("FAIL ovf_drop: overflow=%b dout=%0d expected 1/1", overflow, dout);
    end
    dout_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (dout_valid !== 1'b1 || dout !== exp_w[i]) begin
        failures++;
        $display("FAIL ovf_pop%0d: valid=%b dout=%0d expected 1/%0d", i, dout_valid, dout, exp_w[i]);
      end
      tick();
    end
    checks++;
    if (dout_valid !== 1'b0 || overflow !== 1'b1) begin
      failures++;
      $display("FAIL ovf_empty: valid=%b overflow=%b expected 0/1", dout_valid, overflow);
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
  endtask

  task automatic test_full_pushpop();
    logic [7:0] exp_w [4] = '{8'd6, 8'd7, 8'd8, 8'd9};
    dout_ready = 1'b0;
    for (int w = 5; w <= 8; w++) send_word(8'(w));
    phase_sync = 1'b1;
    tick();
    phase_sync = 1'b0;
    ad_t = 8'd9; ad_f = ~8'd9;
    dout_ready = 1'b1;
    checks++;
    if (dout !== 8'd5) begin
      failures++;
      $display("FAIL pp_head: dout=%0d expected 5", dout);
    end
    tick();
    ad_t = '0; ad_f = '0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (dout_valid !== 1'b1 || dout !== exp_w[i] || overflow !== 1'b0) begin
        failures++;
        $display("FAIL pp_pop%0d: valid=%b dout=%0d overflow=%b expected 1/%0d/0", i, dout_valid, dout, overflow, exp_w[i]);
      end
      tick();
    end
    checks++;
    if (dout_valid !== 1'b0) begin
      failures++;
      $display("FAIL pp_empty: valid=%b expected 0", dout_valid);
    end
  endtask

  task automatic test_reset_mid();
    dout_ready = 1'b0;
    send_word(8'h11);
    send_word(8'h22);
    send_word(8'h33);
    checks++;
    if (dout_valid !== 1'b1 || dout !== 8'h11) begin
      failures++;
      $display("FAIL rst_pre: valid=%b dout=%h expected 1/11", dout_valid, dout);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (dout_valid !== 1'b0 || dout !== 8'h00 || phase !== 2'd0) begin
      failures++;
      $display("FAIL rst_mid: valid=%b dout=%h phase=%0d expected 0/00/0", dout_valid, dout, phase);
    end
    tick();
    rst_n = 1'b1;
    send_word(8'h3C);
    checks++;
    if (dout_valid !== 1'b1 || dout !== 8'h3C) begin
      failures++;
      $display("FAIL rst_first: valid=%b dout=%h expected 1/3c", dout_valid, dout);
    end
    dout_ready = 1'b1;
    tick();
    checks++;
    if (dout_valid !== 1'b0) begin
      failures++;
      $display("FAIL rst_drain: valid=%b expected 0", dout_valid);
    end
  endtask

  initial begin
    test_reset();
    test_phase();
    test_single();
    test_null();
    test_err_sat();
    test_overflow();
    test_full_pushpop();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
